// File: rtl/calibration_sweep_controller_pkg.sv
// Shared types and constants for the dither-threshold calibration slice.
package fpgifa_cal_pkg;

  typedef enum logic [2:0] {IDLE, ALIGN, SWEEP, EVAL, LOCKED} cal_state_t;

  localparam int FRAME_PIXELS = 320 * 240;
  localparam int COUNT_W      = 17;
  localparam int THRESH_W     = 8;

endpackage

// File: rtl/calibration_sweep_controller_if.sv
// Frame-sync / dither-stage bundle for the calibration sweep controller.
// THRESHOLD_OVERRIDE_EN adds the override_en / override_thresh inputs.
interface calibration_sweep_controller_if;
  import fpgifa_cal_pkg::*;

  logic                frame_start;
  logic                dithered_pixel;
  logic                dithered_valid;
  logic                cal_start;
  logic [THRESH_W-1:0] threshold_out;
  logic                calibrating;
  logic                locked;
  logic [COUNT_W-1:0]  best_count;
`ifdef THRESHOLD_OVERRIDE_EN
  logic                override_en;
  logic [THRESH_W-1:0] override_thresh;
`endif

  modport master (
    output frame_start, dithered_pixel, dithered_valid, cal_start,
`ifdef THRESHOLD_OVERRIDE_EN
    output override_en, override_thresh,
`endif
    input  threshold_out, calibrating, locked, best_count
  );

  modport slave (
    input  frame_start, dithered_pixel, dithered_valid, cal_start,
`ifdef THRESHOLD_OVERRIDE_EN
    input  override_en, override_thresh,
`endif
    output threshold_out, calibrating, locked, best_count
  );

endinterface

// File: rtl/calibration_sweep_controller_counter.sv
// pixel_transition_counter: counts valid-pixel transitions within one frame and
// reports the total plus an exact-length check one cycle after frame_start.
module pixel_transition_counter
  import fpgifa_cal_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_PIXELS
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               frame_start,
  input  logic               dithered_pixel,
  input  logic               dithered_valid,
  input  logic               enable,
  output logic [COUNT_W-1:0] count,
  output logic               frame_ok,
  output logic               done
);

  localparam logic [COUNT_W-1:0] LEN = COUNT_W'(FRAME_LEN);

  logic [COUNT_W-1:0] pix_cnt_p0;
  logic [COUNT_W-1:0] trans_cnt_p0;
  logic               have_prev_p0;
  logic               prev_pix_p0;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Running per-frame counters; a pixel coincident with frame_start opens the new frame.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pix_cnt_p0   <= '0;
      trans_cnt_p0 <= '0;
      have_prev_p0 <= 1'b0;
      frame_ok     <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= frame_start & enable;
      if (frame_start) begin
        frame_ok     <= (pix_cnt_p0 == LEN);
        trans_cnt_p0 <= '0;
        if (enable && dithered_valid) begin
          pix_cnt_p0   <= COUNT_W'(1);
          have_prev_p0 <= 1'b1;
        end else begin
          pix_cnt_p0   <= '0;
          have_prev_p0 <= 1'b0;
        end
      end else if (enable && dithered_valid) begin
        pix_cnt_p0   <= sat_inc(pix_cnt_p0);
        have_prev_p0 <= 1'b1;
        if (have_prev_p0 && (dithered_pixel != prev_pix_p0))
          trans_cnt_p0 <= sat_inc(trans_cnt_p0);
      end
    end
  end

  // Data-only registers: frame total snapshot and previous pixel value.
  always_ff @(posedge clk_in) begin
    if (frame_start) count <= trans_cnt_p0;
    if (dithered_valid) prev_pix_p0 <= dithered_pixel;
  end

endmodule

// File: rtl/calibration_sweep_controller.sv
// calibration_sweep_controller: sweeps dither thresholds one frame per step and
// locks threshold_out to the step with the most pixel transitions.
// Optional macro THRESHOLD_OVERRIDE_EN: registered manual threshold override.
module calibration_sweep_controller
  import fpgifa_cal_pkg::*;
#(
  parameter int NUM_STEPS      = 30,
  parameter int START_THRESH   = 0,
  parameter int STEP           = 8,
  parameter int DEFAULT_THRESH = 128,
  parameter int AUTO_START     = 1,
  parameter int FRAME_LEN      = FRAME_PIXELS
) (
  input logic                           clk_in,
  input logic                           rst_in,
  calibration_sweep_controller_if.slave cal_if
);

  localparam int             K_W    = 6;
  localparam logic [K_W-1:0] LAST_K = K_W'(NUM_STEPS - 1);

  cal_state_t          state;
  logic [K_W-1:0]      k;
  logic [K_W-1:0]      best_k;
  logic [COUNT_W-1:0]  best;
  logic [THRESH_W-1:0] thr_fsm;
  logic                calibrating_r;
  logic                locked_r;
  logic [COUNT_W-1:0]  best_count_r;

  logic [COUNT_W-1:0]  count;
  logic                frame_ok;
  logic                done;
  logic                sweep_active;
  logic                frame_good;
  logic                win;
  logic [COUNT_W-1:0]  best_nxt;
  logic [K_W-1:0]      best_k_nxt;

  // Threshold for step idx; the sum is formed wide so large steps clamp at 255 rather than wrap.
  function automatic logic [THRESH_W-1:0] step_thresh(input logic [K_W-1:0] idx);
    int sum;
    sum = START_THRESH + int'(idx) * STEP;
    return (sum > 255) ? 8'd255 : THRESH_W'(sum);
  endfunction

  assign sweep_active = (state == ALIGN) || (state == SWEEP) || (state == EVAL);
  assign frame_good   = done && frame_ok;
  assign win          = frame_good && (count > best);
  assign best_nxt     = win ? count : best;
  assign best_k_nxt   = win ? k : best_k;

  pixel_transition_counter #(.FRAME_LEN(FRAME_LEN)) u_counter (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .frame_start    (cal_if.frame_start),
    .dithered_pixel (cal_if.dithered_pixel),
    .dithered_valid (cal_if.dithered_valid),
    .enable         (sweep_active),
    .count          (count),
    .frame_ok       (frame_ok),
    .done           (done)
  );

  // Sweep sequencer: step/best bookkeeping and registered status outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      k             <= '0;
      best          <= '0;
      best_k        <= '0;
      thr_fsm       <= THRESH_W'(DEFAULT_THRESH);
      calibrating_r <= 1'b0;
      locked_r      <= 1'b0;
      best_count_r  <= '0;
    end else if (cal_if.cal_start && (state inside {ALIGN, SWEEP, EVAL})) begin
      // Abort: restart from ALIGN; threshold holds until ALIGN drives the start value.
      state         <= ALIGN;
      k             <= '0;
      best          <= '0;
      best_k        <= '0;
      calibrating_r <= 1'b1;
      locked_r      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cal_if.cal_start || (AUTO_START != 0)) begin
            state         <= ALIGN;
            calibrating_r <= 1'b1;
          end
        end
        ALIGN: begin
          thr_fsm <= step_thresh('0);
          if (cal_if.frame_start) state <= SWEEP;
        end
        SWEEP: begin
          if (cal_if.frame_start) state <= EVAL;
        end
        EVAL: begin
          best   <= best_nxt;
          best_k <= best_k_nxt;
          if (!frame_good) begin
            state <= SWEEP;
          end else if (k == LAST_K) begin
            state         <= LOCKED;
            thr_fsm       <= step_thresh(best_k_nxt);
            best_count_r  <= best_nxt;
            locked_r      <= 1'b1;
            calibrating_r <= 1'b0;
          end else begin
            state   <= SWEEP;
            k       <= k + 1'b1;
            thr_fsm <= step_thresh(k + 1'b1);
          end
        end
        LOCKED: begin
          if (cal_if.cal_start) begin
            state         <= ALIGN;
            k             <= '0;
            best          <= '0;
            best_k        <= '0;
            locked_r      <= 1'b0;
            calibrating_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cal_if.calibrating = calibrating_r;
  assign cal_if.locked      = locked_r;
  assign cal_if.best_count  = best_count_r;

`ifdef THRESHOLD_OVERRIDE_EN
  logic                ovr_en_p0;
  logic [THRESH_W-1:0] ovr_thr_p0;

  // Override select is control and resets; override value is plain data.
  always_ff @(posedge clk_in) begin
    if (!rst_in) ovr_en_p0 <= 1'b0;
    else         ovr_en_p0 <= cal_if.override_en;
  end

  // Capture override threshold one cycle ahead of use.
  always_ff @(posedge clk_in) begin
    ovr_thr_p0 <= cal_if.override_thresh;
  end

  assign cal_if.threshold_out = ovr_en_p0 ? ovr_thr_p0 : thr_fsm;
`else
  assign cal_if.threshold_out = thr_fsm;
`endif

endmodule

// File: tb/tb_calibration_sweep_controller.sv
// Directed-sequence bench with randomized frame content for calibration_sweep_controller.
module tb_calibration_sweep_controller;

  localparam int NS  = 5;
  localparam int FP  = 64;
  localparam int ST  = 200;
  localparam int SP  = 20;
  localparam int DEF = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calibration_sweep_controller_if cal_if();

  calibration_sweep_controller #(
    .NUM_STEPS(NS), .START_THRESH(ST), .STEP(SP),
    .DEFAULT_THRESH(DEF), .AUTO_START(1), .FRAME_LEN(FP)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .cal_if (cal_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int tgt[NS];
  bit ovr = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference threshold for step k: start + k*step, saturated at 255.
  function automatic int exp_thresh(input int k);
    int v;
    v = ST + k * SP;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int exp_out(input int k);
    return ovr ? 77 : exp_thresh(k);
  endfunction

  task automatic boundary(input bit with_pix, input bit pix);
    cal_if.frame_start    = 1'b1;
    cal_if.dithered_valid = with_pix;
    cal_if.dithered_pixel = pix;
    tick();
    cal_if.frame_start    = 1'b0;
    cal_if.dithered_valid = 1'b0;
    tick();
    tick();
  endtask

  // Builds a frame of n pixels with exactly `target` neighbour changes, then
  // recounts transitions from the pixel list itself and streams it with gaps.
  task automatic pixels(input int n, input int target, input bit has_lead,
                        input bit lead, output int trans);
    bit q[$];
    bit cur;
    int rem;
    int opps;
    if (has_lead) q.push_back(lead);
    else          q.push_back(1'($urandom_range(0, 1)));
    opps = n - 1;
    rem  = (target > opps) ? opps : target;
    for (int i = 0; i < opps; i++) begin
      cur = q[q.size() - 1];
      if (int'($urandom_range(0, opps - 1 - i)) < rem) begin
        cur = ~cur;
        rem--;
      end
      q.push_back(cur);
    end
    trans = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] != q[i-1]) trans++;
    for (int i = int'(has_lead); i < q.size(); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cal_if.dithered_valid = 1'b0;
        tick();
      end
      cal_if.dithered_valid = 1'b1;
      cal_if.dithered_pixel = q[i];
      tick();
    end
    cal_if.dithered_valid = 1'b0;
    tick();
  endtask

  // Full sweep from ALIGN; bad_len != 0 makes the first attempt at step 1 that length.
  task automatic sweep(input int bad_len);
    int k, tr, n, bk, bv;
    int sc[NS];
    bit lead_on, lead_v, bad_used;
    k = 0; lead_on = 0; lead_v = 0; bad_used = 0;
    boundary(1'b0, 1'b0);
    while (k < NS) begin
      chk($sformatf("step%0d_thr", k), cal_if.threshold_out, exp_out(k));
      n = (bad_len != 0 && k == 1 && !bad_used) ? bad_len : FP;
      pixels(n, tgt[k], lead_on, lead_v, tr);
      lead_on = (k < NS - 1) && ($urandom_range(0, 1) == 1);
      lead_v  = 1'($urandom_range(0, 1));
      boundary(lead_on, lead_v);
      if (n == FP) begin
        sc[k] = tr;
        k++;
      end else begin
        bad_used = 1'b1;
      end
    end
    bk = 0;
    bv = sc[0];
    for (int i = 1; i < NS; i++) if (sc[i] > bv) begin bv = sc[i]; bk = i; end
    chk("lock_locked", cal_if.locked, 1);
    chk("lock_calibrating", cal_if.calibrating, 0);
    chk("lock_thr", cal_if.threshold_out, exp_out(bk));
    chk("lock_best_count", cal_if.best_count, bv);
  endtask

  task automatic pulse_cal();
    cal_if.cal_start = 1'b1;
    tick();
    cal_if.cal_start = 1'b0;
    tick();
  endtask

  task automatic tie_targets();
    int t;
    t = $urandom_range(20, 40);
    tgt[0] = $urandom_range(0, t - 1);
    tgt[1] = t;
    tgt[2] = t;
    tgt[3] = $urandom_range(0, t - 1);
    tgt[4] = $urandom_range(0, t - 1);
  endtask

  initial begin
    int tr;
    cal_if.frame_start    = 1'b0;
    cal_if.dithered_pixel = 1'b0;
    cal_if.dithered_valid = 1'b0;
    cal_if.cal_start      = 1'b0;
`ifdef THRESHOLD_OVERRIDE_EN
    cal_if.override_en     = 1'b0;
    cal_if.override_thresh = '0;
`endif
    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rst_thr", cal_if.threshold_out, DEF);
    chk("rst_locked", cal_if.locked, 0);
    chk("rst_calibrating", cal_if.calibrating, 0);
    chk("rst_best_count", cal_if.best_count, 0);

    rst_n = 1'b1;
    tick(); tick();
    chk("auto_calibrating", cal_if.calibrating, 1);
    chk("align_thr", cal_if.threshold_out, ST);

    // Sweep with a tie at steps 1 and 2: the earlier step must win.
    tie_targets();
    sweep(0);

    // cal_start together with frame_start in LOCKED: realign, ignore that frame_start.
    cal_if.cal_start   = 1'b1;
    cal_if.frame_start = 1'b1;
    tick();
    cal_if.cal_start   = 1'b0;
    cal_if.frame_start = 1'b0;
    chk("relock_calibrating", cal_if.calibrating, 1);
    chk("relock_locked", cal_if.locked, 0);
    tick();
    chk("relock_thr", cal_if.threshold_out, ST);

    // Short frame at step 1 repeats the step; step 3 is a fully alternating frame.
    for (int i = 0; i < NS; i++) tgt[i] = $urandom_range(0, 50);
    tgt[3] = FP - 1;
    sweep(FP - 1);

    // Long frame at step 1 also repeats the step.
    pulse_cal();
    for (int i = 0; i < NS; i++) tgt[i] = $urandom_range(0, 60);
    sweep(FP + 1);

    // Abort at step 2: the old high score must not survive into the new sweep.
    pulse_cal();
    boundary(1'b0, 1'b0);
    pixels(FP, 62, 1'b0, 1'b0, tr);
    boundary(1'b0, 1'b0);
    pixels(FP, 10, 1'b0, 1'b0, tr);
    boundary(1'b0, 1'b0);
    chk("abort_k2_thr", cal_if.threshold_out, exp_thresh(2));
    pixels(20, 5, 1'b0, 1'b0, tr);
    cal_if.cal_start = 1'b1;
    tick();
    cal_if.cal_start = 1'b0;
    chk("abort_calibrating", cal_if.calibrating, 1);
    chk("abort_hold_thr", cal_if.threshold_out, exp_thresh(2));
    tick();
    chk("abort_align_thr", cal_if.threshold_out, ST);
    for (int i = 0; i < NS; i++) tgt[i] = $urandom_range(0, 50);
    sweep(0);

    // Reset in the middle of a sweep.
    pulse_cal();
    boundary(1'b0, 1'b0);
    pixels(30, 12, 1'b0, 1'b0, tr);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_thr", cal_if.threshold_out, DEF);
    chk("rst_mid_locked", cal_if.locked, 0);
    chk("rst_mid_calibrating", cal_if.calibrating, 0);
    chk("rst_mid_best_count", cal_if.best_count, 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("auto2_calibrating", cal_if.calibrating, 1);
    chk("auto2_thr", cal_if.threshold_out, ST);

`ifdef THRESHOLD_OVERRIDE_EN
    cal_if.override_en     = 1'b1;
    cal_if.override_thresh = 8'd77;
    ovr = 1'b1;
    tick();
    chk("ovr_thr", cal_if.threshold_out, 77);
`endif
    tie_targets();
    sweep(0);
`ifdef THRESHOLD_OVERRIDE_EN
    cal_if.override_en = 1'b0;
    ovr = 1'b0;
    tick();
    chk("ovr_release_thr", cal_if.threshold_out, exp_thresh(1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
